prog_loader: RTL
================

Name: prog_loader

Overview:
- Parametrised boot/debug loader between an external host byte-word stream and the single-cycle RISC datapath.
- Drives the datapath's external memory-load side channel: test_normal, ext_instr_*, ext_data_* and flag_HLT.
- Decodes a framed command stream to:
  - bulk-load instruction or data memory at any base address;
  - release the CPU to run;
  - halt it again.
- Replaces hand-sequenced bench tasks with a reusable on-chip block.

Parameters:
- DATA_W, 16, memory word width and stream word width.
- ADDR_W, 16, address width of ext_instr_addr / ext_data_addr.
- INSTR_DEPTH, 256, number of valid instruction-memory words; writes at or above this address are dropped.
- DATA_DEPTH, 256, number of valid data-memory words; writes at or above this address are dropped.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  synchronous active-high reset.
- in_valid  in  1  host word valid.
- in_ready  out  1  loader can accept a word this cycle.
- in_data  in  DATA_W  host word.
- test_normal  out  1  1 = external port owns the memories (load mode); 0 = CPU owns them.
- flag_HLT  out  1  1 = CPU halted.
- ext_instr_we  out  1  instruction-memory write strobe, one cycle per word.
- ext_instr_addr  out  ADDR_W  instruction write address.
- ext_instr_data  out  DATA_W  instruction write data.
- ext_data_write_en  out  1  data-memory write strobe.
- ext_data_addr  out  ADDR_W  data write address.
- ext_data_data  out  DATA_W  data write data.
- busy  out  1  1 while a load frame is in progress.
- err  out  1  sticky error; cleared by clr or by a CLRERR command.
- words_written  out  ADDR_W  count of words actually written in the last frame.

Behaviour:
- Reset (clr=1 at a clk edge), regardless of state:
  - state=IDLE, flag_HLT=1, test_normal=1;
  - all write strobes 0; addresses/data 0;
  - busy=0, err=0, words_written=0, in_ready=0 in that cycle.
  - A reset mid-frame abandons the frame; no further writes.
- Handshake:
  - A word transfers on a clk edge with in_valid && in_ready.
  - in_ready=1 in every state except the reset cycle.
  - in_data must be held stable while in_valid=1 and in_ready=0.
- Command word, accepted in IDLE or RUN:
  - in_data[DATA_W-1:DATA_W-3] = opcode: 000 LOAD_I, 001 LOAD_D, 010 RUN, 011 HALT, 100 CLRERR.
  - Other opcodes are ignored and set err.
- FSM states: IDLE, HDR_ADDR, HDR_LEN, LOAD, RUN.
- IDLE:
  - LOAD_I / LOAD_D: latch target, go to HDR_ADDR, busy=1.
  - RUN: go to RUN.
  - HALT: no-op.
  - CLRERR: err=0.
- HDR_ADDR: the accepted word is the base address (low ADDR_W bits); go to HDR_LEN.
- HDR_LEN:
  - The accepted word is N, the word count.
  - N=0: set err, busy=0, go to IDLE.
  - Otherwise clear words_written and go to LOAD.
- LOAD:
  - Each accepted word produces exactly one write on the following cycle: strobe high for exactly one cycle, address = base+k, data = word. Latency is 1 cycle from acceptance to strobe.
  - Only the selected target's strobe may assert.
  - If base+k >= target DEPTH, or the address has wrapped past 2^ADDR_W, suppress the write, set err, but still consume the word.
  - words_written increments only on actual writes.
  - After the Nth word is accepted: busy=0, go to IDLE.
- RUN:
  - On entry (the cycle after the RUN command is accepted): test_normal=0, flag_HLT=0.
  - HALT: flag_HLT=1 and test_normal=1 on the next cycle, go to IDLE.
  - CLRERR: err=0.
  - LOAD_I / LOAD_D: ignored and set err, so memories are never written while the CPU runs.
- Outside RUN, flag_HLT=1 and test_normal=1 always.
- No write strobe may coincide with test_normal=0.
- Simultaneous clr and a valid word: clr wins; the word is not consumed.

Decomposition:
- Shared package prog_loader_pkg:
  - opcode constants OP_LOAD_I, OP_LOAD_D, OP_RUN, OP_HALT, OP_CLRERR;
  - the FSM state encoding typedef;
  - the header field positions.
- One natural sub-module, ldr_write_port: the registered address counter, range check and one-cycle write-strobe generator, instantiated once and steered by target.

Test Plan:
- clr for 2 cycles -> flag_HLT=1, test_normal=1, all strobes 0, err=0, busy=0.
- Stream 0x0000, 0x0000, 0x0002, 0x0001, 0x0002 (LOAD_I) -> ext_instr_we pulses at addr 0 data 0x0001, then addr 1 data 0x0002, each one cycle after acceptance; words_written=2; ext_data_write_en never asserts.
- Stream 0x2000, 0x00FE, 0x0003, 0x0011, 0x0022, 0x0033 (LOAD_D, DATA_DEPTH=256) -> writes at 0xFE and 0xFF only; err=1; words_written=2; all three words consumed.
- Stream 0x4000 (RUN), then 0x0000, 0x0000, 0x0001, 0xBEEF -> test_normal=0 and flag_HLT=0; err=1; no instruction write. Then 0x6000 (HALT) -> flag_HLT=1, test_normal=1.
- LOAD_I with N=4, in_valid toggled every other cycle -> exactly 4 strobes at addresses base..base+3 with no duplicates; busy falls after the 4th word.
- clr asserted after the 2nd of 4 data words -> no further strobes; state IDLE; the next command frame loads normally.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: opcodes, FSM state encoding and command-word field layout for prog_loader
package prog_loader_pkg;
  localparam int OPC_W = 3;
  localparam int HDR_ADDR_LSB = 0;
  localparam int HDR_LEN_LSB = 0;
  localparam logic [OPC_W-1:0] OP_LOAD_I = 3'b000;
  localparam logic [OPC_W-1:0] OP_LOAD_D = 3'b001;
  localparam logic [OPC_W-1:0] OP_RUN = 3'b010;
  localparam logic [OPC_W-1:0] OP_HALT = 3'b011;
  localparam logic [OPC_W-1:0] OP_CLRERR = 3'b100;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_ADDR,
    ST_HDR_LEN,
    ST_LOAD,
    ST_RUN
  } state_e;
  function automatic logic is_load(input logic [OPC_W-1:0] op);
    return op == OP_LOAD_I || op == OP_LOAD_D;
  endfunction
endpackage

// File: rtl/ldr_write_port.sv
// ldr_write_port: address counter, range check and one-cycle write strobe for the selected memory
//   clk/clr      clock, sync active-high reset
//   base_ld_i    load base_i into the address counter
//   cnt_clr_i    clear the written-word counter
//   wr_i         a data word is accepted this cycle (wdata_i)
//   sel_i        target: 0 instruction memory, 1 data memory
//   instr_we_o / data_we_o, addr_o, data_o   registered write port
//   oob_o        accepted word falls outside the target memory (write dropped)
//   words_o      number of words actually written since cnt_clr_i
module ldr_write_port #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int INSTR_DEPTH = 256,
  parameter int DATA_DEPTH = 256
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              base_ld_i,
  input  logic              cnt_clr_i,
  input  logic              wr_i,
  input  logic              sel_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              instr_we_o,
  output logic              data_we_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  output logic              oob_o,
  output logic [ADDR_W-1:0] words_o
);
  logic [ADDR_W-1:0] ptr_q;
  logic              wrap_q;
  logic              in_range;
  logic              go;
  // wrap_q is sticky so an address that rolled past 2^ADDR_W never looks valid again
  always_comb begin
    in_range = !wrap_q && (32'(ptr_q) < 32'(sel_i ? DATA_DEPTH : INSTR_DEPTH));
    go = wr_i && in_range;
    oob_o = wr_i && !in_range;
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      ptr_q <= '0;
      wrap_q <= 1'b0;
      instr_we_o <= 1'b0;
      data_we_o <= 1'b0;
      addr_o <= '0;
      data_o <= '0;
      words_o <= '0;
    end else begin
      instr_we_o <= go && !sel_i;
      data_we_o <= go && sel_i;
      if (base_ld_i) begin
        ptr_q <= base_i;
        wrap_q <= 1'b0;
      end else if (wr_i) begin
        ptr_q <= ptr_q + 1'b1;
        wrap_q <= wrap_q || (&ptr_q);
      end
      if (go) begin
        addr_o <= ptr_q;
        data_o <= wdata_i;
      end
      words_o <= cnt_clr_i ? '0 : words_o + ADDR_W'(go);
    end
  end
endmodule

// File: rtl/prog_loader.sv
// prog_loader: framed host-stream loader/run controller for the RISC datapath memory side channel
//   clk/clr             clock, sync active-high reset
//   in_valid/in_ready/in_data   host word stream (transfer on valid && ready)
//   test_normal         1 = loader owns memories, 0 = CPU runs
//   flag_HLT            1 = CPU halted
//   ext_instr_*         instruction-memory write port
//   ext_data_*          data-memory write port
//   busy                load frame in progress
//   err                 sticky error flag
//   words_written       words written by the last frame
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int INSTR_DEPTH = 256,
  parameter int DATA_DEPTH = 256
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              test_normal,
  output logic              flag_HLT,
  output logic              ext_instr_we,
  output logic [ADDR_W-1:0] ext_instr_addr,
  output logic [DATA_W-1:0] ext_instr_data,
  output logic              ext_data_write_en,
  output logic [ADDR_W-1:0] ext_data_addr,
  output logic [DATA_W-1:0] ext_data_data,
  output logic              busy,
  output logic              err,
  output logic [ADDR_W-1:0] words_written
);
  state_e            state_q, state_d;
  logic              target_q, target_d;
  logic [DATA_W-1:0] remain_q, remain_d;
  logic              err_q, err_d;
  logic              acc, base_ld, cnt_clr, wr, oob;
  logic [OPC_W-1:0]  op;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  assign op = in_data[DATA_W-1 -: OPC_W];
  assign acc = in_valid && in_ready;
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_IDLE;
      target_q <= 1'b0;
      remain_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      target_q <= target_d;
      remain_q <= remain_d;
      err_q <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    target_d = target_q;
    remain_d = remain_q;
    err_d = err_q;
    base_ld = 1'b0;
    cnt_clr = 1'b0;
    wr = 1'b0;
    if (acc) begin
      case (state_q)
        ST_IDLE: begin
          if (is_load(op)) begin
            state_d = ST_HDR_ADDR;
            target_d = op == OP_LOAD_D;
          end else if (op == OP_RUN) state_d = ST_RUN;
          else if (op == OP_CLRERR) err_d = 1'b0;
          else if (op != OP_HALT) err_d = 1'b1;
        end
        ST_HDR_ADDR: begin
          base_ld = 1'b1;
          state_d = ST_HDR_LEN;
        end
        ST_HDR_LEN: begin
          if (in_data == '0) begin
            err_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            remain_d = in_data[HDR_LEN_LSB +: DATA_W];
            cnt_clr = 1'b1;
            state_d = ST_LOAD;
          end
        end
        ST_LOAD: begin
          wr = 1'b1;
          err_d = err_q || oob;
          remain_d = remain_q - 1'b1;
          state_d = remain_q == DATA_W'(1) ? ST_IDLE : ST_LOAD;
        end
        ST_RUN: begin
          // loads are refused while the CPU owns the memories
          if (op == OP_HALT) state_d = ST_IDLE;
          else if (op == OP_CLRERR) err_d = 1'b0;
          else if (op != OP_RUN) err_d = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end
  always_comb begin
    in_ready = !clr;
    busy = state_q inside {ST_HDR_ADDR, ST_HDR_LEN, ST_LOAD};
    test_normal = state_q != ST_RUN;
    flag_HLT = state_q != ST_RUN;
    err = err_q;
    ext_instr_addr = wr_addr;
    ext_instr_data = wr_data;
    ext_data_addr = wr_addr;
    ext_data_data = wr_data;
  end
  ldr_write_port #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .INSTR_DEPTH(INSTR_DEPTH),
    .DATA_DEPTH(DATA_DEPTH)
  ) u_wp (
    .clk(clk),
    .clr(clr),
    .base_ld_i(base_ld),
    .cnt_clr_i(cnt_clr),
    .wr_i(wr),
    .sel_i(target_q),
    .base_i(ADDR_W'(in_data[HDR_ADDR_LSB +: ADDR_W])),
    .wdata_i(in_data),
    .instr_we_o(ext_instr_we),
    .data_we_o(ext_data_write_en),
    .addr_o(wr_addr),
    .data_o(wr_data),
    .oob_o(oob),
    .words_o(words_written)
  );
endmodule
